// File: rtl/conv_channel_err_inj_if.sv
`default_nettype none
// ============================================================================
// conv_channel_err_inj_if : encoded-symbol stream in/out of the channel model
// Rev 1.0
// ============================================================================
interface conv_channel_err_inj_if #(
  parameter int SYM_W = 2
);
  logic             in_valid;
  logic [SYM_W-1:0] in_sym;
  logic             out_valid;
  logic [SYM_W-1:0] out_sym;
  logic [SYM_W-1:0] out_err;

  modport master (output in_valid, in_sym, input out_valid, out_sym, out_err);
  modport slave  (input in_valid, in_sym, output out_valid, out_sym, out_err);
endinterface
`default_nettype wire

// File: rtl/conv_channel_err_inj.sv
`default_nettype none
// ============================================================================
// conv_channel_err_inj : noisy-channel model with periodic bit/symbol/burst errors
// Rev 1.0
// ============================================================================
module conv_channel_err_inj #(
  parameter int SYM_W     = 2,
  parameter int PERIOD_W  = 8,
  parameter int BURST_MAX = 8,
  parameter int CNT_W     = 16,
  localparam int BSEL_W   = (SYM_W > 1) ? $clog2(SYM_W) : 1,
  localparam int LEN_W    = $clog2(BURST_MAX + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_en,
  input  logic [1:0]          cfg_mode,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic [PERIOD_W-1:0] cfg_offset,
  input  logic [BSEL_W-1:0]   cfg_bit_sel,
  input  logic [LEN_W-1:0]    cfg_burst_len,
  input  logic                clr_stats,
  conv_channel_err_inj_if.slave ch,
  output logic [CNT_W-1:0]    sym_ct,
  output logic [CNT_W-1:0]    err_sym_ct,
  output logic [CNT_W-1:0]    err_bit_ct
);

  localparam logic [1:0] MODE_OFF    = 2'd0;
  localparam logic [1:0] MODE_SINGLE = 2'd1;
  localparam logic [1:0] MODE_BURST  = 2'd3;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(BURST_MAX);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam int PC_W = $clog2(SYM_W + 1);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BURST = 1'b1} state_t;

  state_t              state;
  logic [PERIOD_W-1:0] pos;
  logic [LEN_W-1:0]    remaining;
  logic                trigger;
  logic [SYM_W-1:0]    bit_mask;
  logic [SYM_W-1:0]    mask;
  logic [LEN_W-1:0]    len;
  logic [PC_W-1:0]     flips;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? CNT_MAX : s[CNT_W-1:0];
  endfunction

  always_comb begin
    trigger = ch.in_valid && cfg_en && (cfg_mode != MODE_OFF) &&
              (cfg_period != '0) && (cfg_offset < cfg_period) && (pos == cfg_offset);

    // An out-of-range bit select shifts the one-hot out entirely; fall back to bit 0.
    bit_mask = SYM_W'(1) << cfg_bit_sel;
    if (bit_mask == '0) bit_mask = SYM_W'(1);

    if (cfg_burst_len == '0)         len = LEN_ONE;
    else if (cfg_burst_len > LEN_MAX) len = LEN_MAX;
    else                              len = cfg_burst_len;

    // An active burst overrides the mode so mid-burst reconfiguration cannot cut it short.
    mask = '0;
    if (ch.in_valid && cfg_en) begin
      if (state == ST_BURST) mask = '1;
      else if (trigger)      mask = (cfg_mode == MODE_SINGLE) ? bit_mask : '1;
    end

    flips = '0;
    for (int i = 0; i < SYM_W; i++) flips = flips + PC_W'(mask[i]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ch.out_valid <= 1'b0;
      ch.out_sym   <= '0;
      ch.out_err   <= '0;
      pos          <= '0;
      state        <= ST_IDLE;
      remaining    <= '0;
      sym_ct       <= '0;
      err_sym_ct   <= '0;
      err_bit_ct   <= '0;
    end else begin
      ch.out_valid <= ch.in_valid;
      ch.out_sym   <= ch.in_sym ^ mask;
      ch.out_err   <= mask;

      if (!cfg_en || cfg_period == '0)
        pos <= '0;
      else if (ch.in_valid)
        pos <= (pos == cfg_period - PERIOD_W'(1)) ? '0 : pos + PERIOD_W'(1);

      if (!cfg_en) begin
        state     <= ST_IDLE;
        remaining <= '0;
      end else if (ch.in_valid) begin
        case (state)
          ST_IDLE: begin
            if (trigger && cfg_mode == MODE_BURST) begin
              remaining <= len - LEN_ONE;
              if (len != LEN_ONE) state <= ST_BURST;
            end
          end
          ST_BURST: begin
            remaining <= remaining - LEN_ONE;
            if (remaining == LEN_ONE) state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end

      if (clr_stats) begin
        sym_ct     <= '0;
        err_sym_ct <= '0;
        err_bit_ct <= '0;
      end else if (ch.in_valid) begin
        sym_ct     <= sat_add(sym_ct, CNT_W'(1));
        err_sym_ct <= sat_add(err_sym_ct, CNT_W'(mask != '0));
        err_bit_ct <= sat_add(err_bit_ct, CNT_W'(flips));
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv_channel_err_inj.sv
`default_nettype none
// ============================================================================
// tb_conv_channel_err_inj : directed checks of the channel error injector
// Rev 1.0
// ============================================================================
module tb_conv_channel_err_inj;

  localparam int SYM_W     = 2;
  localparam int PERIOD_W  = 8;
  localparam int BURST_MAX = 8;
  localparam int CNT_W     = 16;
  localparam int CNT_W_S   = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                cfg_en = 1'b0;
  logic [1:0]          cfg_mode = 2'd0;
  logic [PERIOD_W-1:0] cfg_period = '0;
  logic [PERIOD_W-1:0] cfg_offset = '0;
  logic [0:0]          cfg_bit_sel = '0;
  logic [3:0]          cfg_burst_len = '0;
  logic                clr_stats = 1'b0;
  logic [CNT_W-1:0]    sym_ct, err_sym_ct, err_bit_ct;
  logic [CNT_W_S-1:0]  sym_ct_s, err_sym_ct_s, err_bit_ct_s;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  conv_channel_err_inj_if #(.SYM_W(SYM_W)) ch ();
  conv_channel_err_inj_if #(.SYM_W(SYM_W)) ch_s ();
  assign ch_s.in_valid = ch.in_valid;
  assign ch_s.in_sym   = ch.in_sym;

  conv_channel_err_inj #(.SYM_W(SYM_W), .PERIOD_W(PERIOD_W), .BURST_MAX(BURST_MAX), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_mode(cfg_mode), .cfg_period(cfg_period),
    .cfg_offset(cfg_offset), .cfg_bit_sel(cfg_bit_sel), .cfg_burst_len(cfg_burst_len),
    .clr_stats(clr_stats), .ch(ch), .sym_ct(sym_ct), .err_sym_ct(err_sym_ct), .err_bit_ct(err_bit_ct)
  );

  // Narrow-counter copy fed with the same stream, used for saturation checks.
  conv_channel_err_inj #(.SYM_W(SYM_W), .PERIOD_W(PERIOD_W), .BURST_MAX(BURST_MAX), .CNT_W(CNT_W_S)) dut_s (
    .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_mode(cfg_mode), .cfg_period(cfg_period),
    .cfg_offset(cfg_offset), .cfg_bit_sel(cfg_bit_sel), .cfg_burst_len(cfg_burst_len),
    .clr_stats(clr_stats), .ch(ch_s), .sym_ct(sym_ct_s), .err_sym_ct(err_sym_ct_s), .err_bit_ct(err_bit_ct_s)
  );

  task automatic step(input logic v, input logic [SYM_W-1:0] s);
    ch.in_valid = v;
    ch.in_sym   = s;
    @(posedge clk);
    #1;
  endtask

  task automatic pattern_restart();
    cfg_en    = 1'b0;
    clr_stats = 1'b1;
    step(1'b0, 2'b00);
    clr_stats = 1'b0;
  endtask

  task automatic test_reset();
    ch.in_valid = 1'b1; ch.in_sym = 2'b11;
    cfg_en = 1'b1; cfg_mode = 2'd2; cfg_period = 8'd1; cfg_offset = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (ch.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid: got %b want 0", ch.out_valid); end
    n_cmp++; if (ch.out_sym !== 2'b00) begin n_fail++; $display("FAIL reset out_sym: got %b want 00", ch.out_sym); end
    n_cmp++; if (ch.out_err !== 2'b00) begin n_fail++; $display("FAIL reset out_err: got %b want 00", ch.out_err); end
    n_cmp++; if (sym_ct !== 16'd0 || err_sym_ct !== 16'd0 || err_bit_ct !== 16'd0) begin
      n_fail++; $display("FAIL reset counters: got %0d/%0d/%0d want 0/0/0", sym_ct, err_sym_ct, err_bit_ct); end
    n_cmp++; if (sym_ct_s !== 4'd0) begin n_fail++; $display("FAIL reset small sym_ct: got %0d want 0", sym_ct_s); end
    ch.in_valid = 1'b0; ch.in_sym = 2'b00; cfg_en = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_bit();
    logic [SYM_W-1:0] e;
    pattern_restart();
    cfg_en = 1'b1; cfg_mode = 2'd1; cfg_period = 8'd4; cfg_offset = 8'd1; cfg_bit_sel = 1'b1;
    n_cmp++; if (ch.out_valid !== 1'b0) begin n_fail++; $display("FAIL single idle out_valid: got %b want 0", ch.out_valid); end
    for (int k = 0; k < 16; k++) begin
      step(1'b1, 2'b00);
      e = (k % 4 == 1) ? 2'b10 : 2'b00;
      n_cmp++; if (ch.out_valid !== 1'b1 || ch.out_sym !== e || ch.out_err !== e) begin
        n_fail++; $display("FAIL single sym %0d: got v=%b sym=%b err=%b want v=1 sym=%b err=%b", k, ch.out_valid, ch.out_sym, ch.out_err, e, e); end
    end
    step(1'b0, 2'b00);
    n_cmp++; if (ch.out_valid !== 1'b0) begin n_fail++; $display("FAIL single trailing out_valid: got %b want 0", ch.out_valid); end
    n_cmp++; if (sym_ct !== 16'd16 || err_sym_ct !== 16'd4 || err_bit_ct !== 16'd4) begin
      n_fail++; $display("FAIL single stats: got %0d/%0d/%0d want 16/4/4", sym_ct, err_sym_ct, err_bit_ct); end
  endtask

  task automatic test_full_sym();
    logic [SYM_W-1:0] s, e;
    pattern_restart();
    cfg_en = 1'b1; cfg_mode = 2'd2; cfg_period = 8'd16; cfg_offset = 8'd1;
    for (int k = 0; k < 256; k++) begin
      s = SYM_W'(k);
      step(1'b1, s);
      e = (k % 16 == 1) ? 2'b11 : 2'b00;
      n_cmp++; if (ch.out_sym !== (s ^ e) || ch.out_err !== e) begin
        n_fail++; $display("FAIL full sym %0d: got sym=%b err=%b want sym=%b err=%b", k, ch.out_sym, ch.out_err, s ^ e, e); end
    end
    step(1'b0, 2'b00);
    n_cmp++; if (sym_ct !== 16'd256 || err_sym_ct !== 16'd16 || err_bit_ct !== 16'd32) begin
      n_fail++; $display("FAIL full stats: got %0d/%0d/%0d want 256/16/32", sym_ct, err_sym_ct, err_bit_ct); end
  endtask

  task automatic test_burst();
    logic [SYM_W-1:0] e;
    pattern_restart();
    cfg_en = 1'b1; cfg_mode = 2'd3; cfg_period = 8'd8; cfg_offset = 8'd2; cfg_burst_len = 4'd3;
    for (int k = 0; k < 24; k++) begin
      step(1'b1, 2'b00);
      e = (k % 8 >= 2 && k % 8 <= 4) ? 2'b11 : 2'b00;
      n_cmp++; if (ch.out_err !== e) begin n_fail++; $display("FAIL burst3 sym %0d: got err=%b want %b", k, ch.out_err, e); end
    end
    n_cmp++; if (err_sym_ct !== 16'd9 || err_bit_ct !== 16'd18) begin
      n_fail++; $display("FAIL burst3 stats: got %0d/%0d want 9/18", err_sym_ct, err_bit_ct); end
    pattern_restart();
    cfg_en = 1'b1; cfg_period = 8'd16; cfg_burst_len = 4'd12;
    for (int k = 0; k < 32; k++) begin
      step(1'b1, 2'b00);
      e = (k % 16 >= 2 && k % 16 <= 9) ? 2'b11 : 2'b00;
      n_cmp++; if (ch.out_err !== e) begin n_fail++; $display("FAIL burst clamp sym %0d: got err=%b want %b", k, ch.out_err, e); end
    end
    n_cmp++; if (err_sym_ct !== 16'd16) begin n_fail++; $display("FAIL burst clamp err_sym_ct: got %0d want 16", err_sym_ct); end
  endtask

  task automatic test_burst_overlap();
    logic [SYM_W-1:0] e;
    pattern_restart();
    cfg_en = 1'b1; cfg_mode = 2'd3; cfg_period = 8'd4; cfg_offset = 8'd0; cfg_burst_len = 4'd6;
    for (int k = 0; k < 16; k++) begin
      step(1'b1, 2'b00);
      e = (k % 8 < 6) ? 2'b11 : 2'b00;
      n_cmp++; if (ch.out_err !== e) begin n_fail++; $display("FAIL overlap sym %0d: got err=%b want %b", k, ch.out_err, e); end
    end
  endtask

  task automatic test_gaps_abort();
    // Each entry: {in_valid, cfg_en, corrupted}.
    bit [2:0] tab [21] = '{3'b110, 3'b111, 3'b010, 3'b010, 3'b111, 3'b111, 3'b010, 3'b111,
                           3'b110, 3'b110, 3'b110, 3'b110, 3'b111, 3'b111, 3'b100, 3'b110,
                           3'b111, 3'b111, 3'b111, 3'b111, 3'b110};
    logic [SYM_W-1:0] e;
    int nv, ne;
    nv = 0; ne = 0;
    pattern_restart();
    cfg_mode = 2'd3; cfg_period = 8'd8; cfg_offset = 8'd1; cfg_burst_len = 4'd4;
    for (int k = 0; k < 21; k++) begin
      cfg_en = tab[k][1];
      step(tab[k][2], 2'b01);
      e = tab[k][0] ? 2'b11 : 2'b00;
      if (tab[k][2]) nv++;
      if (tab[k][0]) ne++;
      n_cmp++; if (ch.out_valid !== tab[k][2] || ch.out_err !== e || ch.out_sym !== (2'b01 ^ e)) begin
        n_fail++; $display("FAIL gaps step %0d: got v=%b err=%b sym=%b want v=%b err=%b sym=%b",
                           k, ch.out_valid, ch.out_err, ch.out_sym, tab[k][2], e, 2'b01 ^ e); end
    end
    n_cmp++; if (sym_ct !== CNT_W'(nv) || err_sym_ct !== CNT_W'(ne) || err_bit_ct !== CNT_W'(2 * ne)) begin
      n_fail++; $display("FAIL gaps stats: got %0d/%0d/%0d want %0d/%0d/%0d", sym_ct, err_sym_ct, err_bit_ct, nv, ne, 2 * ne); end
  endtask

  task automatic test_saturation();
    pattern_restart();
    cfg_en = 1'b1; cfg_mode = 2'd2; cfg_period = 8'd1; cfg_offset = 8'd0;
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 2'b00);
      if (k == 7) begin
        n_cmp++; if (err_bit_ct_s !== 4'd15) begin n_fail++; $display("FAIL sat bits at 8 syms: got %0d want 15", err_bit_ct_s); end
      end
    end
    n_cmp++; if (sym_ct !== 16'd20 || err_sym_ct !== 16'd20 || err_bit_ct !== 16'd40) begin
      n_fail++; $display("FAIL sat wide stats: got %0d/%0d/%0d want 20/20/40", sym_ct, err_sym_ct, err_bit_ct); end
    n_cmp++; if (sym_ct_s !== 4'd15 || err_sym_ct_s !== 4'd15 || err_bit_ct_s !== 4'd15) begin
      n_fail++; $display("FAIL sat narrow stats: got %0d/%0d/%0d want 15/15/15", sym_ct_s, err_sym_ct_s, err_bit_ct_s); end
    clr_stats = 1'b1;
    step(1'b1, 2'b00);
    clr_stats = 1'b0;
    n_cmp++; if (ch.out_err !== 2'b11) begin n_fail++; $display("FAIL clr out_err: got %b want 11", ch.out_err); end
    n_cmp++; if (sym_ct !== 16'd0 || err_sym_ct !== 16'd0 || err_bit_ct !== 16'd0 || err_sym_ct_s !== 4'd0) begin
      n_fail++; $display("FAIL clr counters: got %0d/%0d/%0d/%0d want 0/0/0/0", sym_ct, err_sym_ct, err_bit_ct, err_sym_ct_s); end
    step(1'b1, 2'b00);
    n_cmp++; if (sym_ct !== 16'd1 || err_sym_ct !== 16'd1 || err_bit_ct !== 16'd2) begin
      n_fail++; $display("FAIL post-clr stats: got %0d/%0d/%0d want 1/1/2", sym_ct, err_sym_ct, err_bit_ct); end
  endtask

  task automatic test_reset_mid_burst();
    pattern_restart();
    cfg_en = 1'b1; cfg_mode = 2'd3; cfg_period = 8'd16; cfg_offset = 8'd1; cfg_burst_len = 4'd8;
    step(1'b1, 2'b00);
    step(1'b1, 2'b00);
    step(1'b1, 2'b00);
    n_cmp++; if (ch.out_err !== 2'b11) begin n_fail++; $display("FAIL pre-reset burst err: got %b want 11", ch.out_err); end
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (ch.out_err !== 2'b00 || ch.out_valid !== 1'b0 || sym_ct !== 16'd0) begin
      n_fail++; $display("FAIL async reset: got err=%b v=%b sym_ct=%0d want 00/0/0", ch.out_err, ch.out_valid, sym_ct); end
    @(posedge clk);
    #1 rst = 1'b1;
    step(1'b1, 2'b00);
    n_cmp++; if (ch.out_err !== 2'b00) begin n_fail++; $display("FAIL post-reset pos0 err: got %b want 00", ch.out_err); end
    step(1'b1, 2'b00);
    n_cmp++; if (ch.out_err !== 2'b11) begin n_fail++; $display("FAIL post-reset pos1 err: got %b want 11", ch.out_err); end
  endtask

  initial begin
    ch.in_valid = 1'b0;
    ch.in_sym   = 2'b00;
    test_reset();
    test_single_bit();
    test_full_sym();
    test_burst();
    test_burst_overlap();
    test_gaps_abort();
    test_saturation();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
